// File: rtl/hanoi_pkg.sv
// Shared types and helpers for the Tower of Hanoi move generator.
package hanoi_pkg;

    typedef logic [1:0] rod_t;

    localparam rod_t ROD0 = 2'd0;
    localparam rod_t ROD1 = 2'd1;
    localparam rod_t ROD2 = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } solver_state_e;

    // For an even disk count the natural sequence lands on rod 1;
    // exchanging rods 1 and 2 retargets it onto rod 2.
    function automatic rod_t swap12(input rod_t r);
        case (r)
            ROD1:    return ROD2;
            ROD2:    return ROD1;
            default: return r;
        endcase
    endfunction

    // Sum of two residues (each 0..2), reduced mod 3.
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/hanoi_mod3.sv
// Combinational W-bit unsigned modulo 3.
// Since 4 == 1 (mod 3), the value mod 3 equals the sum of its base-4 digits
// mod 3; the digits are folded pairwise in a balanced tree.
module hanoi_mod3
    import hanoi_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] x,
    output logic [1:0]   y
);

    localparam int N    = (W + 1) / 2;     // base-4 digits
    localparam int LVLS = $clog2(N);       // tree depth
    localparam int NP   = 1 << LVLS;       // digits padded to a power of two

    logic [2*NP-1:0] xp;

    assign xp = (2*NP)'(x);

    genvar gi, gj;
    generate
        for (gi = 0; gi <= LVLS; gi++) begin : g_lvl
            localparam int CNT = NP >> gi;
            logic [1:0] r [CNT];
            if (gi == 0) begin : g_leaf
                for (gj = 0; gj < CNT; gj++) begin : g_dig
                    // A single digit of value 3 is already 0 mod 3.
                    assign r[gj] = (xp[2*gj +: 2] == 2'd3) ? 2'd0 : xp[2*gj +: 2];
                end
            end else begin : g_node
                for (gj = 0; gj < CNT; gj++) begin : g_add
                    assign r[gj] = mod3_add(g_lvl[gi-1].r[2*gj], g_lvl[gi-1].r[2*gj+1]);
                end
            end
        end
    endgenerate

    assign y = g_lvl[LVLS].r[0];

endmodule

// File: rtl/hanoi_solver.sv
// Tower of Hanoi optimal move generator (S disks, rod 0 -> rod 2).
// Move k is decoded directly from the move index:
//   from = (k & (k-1)) mod 3, to = ((k | (k-1)) + 1) mod 3, rods 1/2 swapped for even S.
// Optional build macro HANOI_SOLVER_CHECK_EN adds a shadow puzzle model that
// raises a sticky 'illegal' flag on any rule violation or wrong final state.
module hanoi_solver
    import hanoi_pkg::*;
#(
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         mv_ready,
    output logic         mv_valid,
    output logic [1:0]   mv_fr,
    output logic [1:0]   mv_to,
    output logic         busy,
    output logic         done,
    output logic [S-1:0] move_cnt,
    output logic         illegal
);

    localparam int         W      = S + 1;
    localparam logic [S-1:0] K_LAST = '1;

    solver_state_e state_q, state_d;
    logic [S-1:0]  k_q, k_d;
    logic [S-1:0]  move_cnt_q, move_cnt_d;
    logic          hs;
    logic          restart;

    logic [W-1:0]  k_ext, km1_ext, f_raw, t_raw;
    logic [1:0]    f_mod, t_mod;
    rod_t          fr_rod, to_rod;

    assign k_ext   = {1'b0, k_q};
    assign km1_ext = k_ext - W'(1);
    assign f_raw   = k_ext & km1_ext;
    assign t_raw   = (k_ext | km1_ext) + W'(1);

    hanoi_mod3 #(.W(W)) u_mod3_f (.x(f_raw), .y(f_mod));
    hanoi_mod3 #(.W(W)) u_mod3_t (.x(t_raw), .y(t_mod));

    assign mv_valid = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign move_cnt = move_cnt_q;
    assign hs       = mv_valid & mv_ready;
    assign restart  = start & ((state_q == IDLE) | (state_q == DONE));

    // Rod decode with even-S retarget; outputs parked at rod 0 when no move is offered.
    always_comb begin
        fr_rod = f_mod;
        to_rod = t_mod;
        if ((S % 2) == 0) begin
            fr_rod = swap12(f_mod);
            to_rod = swap12(t_mod);
        end
        mv_fr = mv_valid ? fr_rod : ROD0;
        mv_to = mv_valid ? to_rod : ROD0;
    end

    // Next-state logic: start launches a solve, each handshake advances k.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        move_cnt_d = move_cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    k_d        = S'(1);
                    move_cnt_d = '0;
                end
            end
            RUN: begin
                if (hs) begin
                    move_cnt_d = move_cnt_q + S'(1);
                    // The last move exits RUN instead of incrementing, so k never wraps.
                    if (k_q == K_LAST) begin
                        state_d = DONE;
                    end else begin
                        k_d = k_q + S'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, move index and accepted-move counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= S'(1);
            move_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            move_cnt_q <= move_cnt_d;
        end
    end

`ifdef HANOI_SOLVER_CHECK_EN
    logic [S-1:0] rod_q [3];
    logic [S-1:0] rod_d [3];
    logic         illegal_q, illegal_d;
    logic [S-1:0] src, tgt, mv_bit, tgt_low;

    // Shadow puzzle: move the smallest disk of the source rod, flag rule breaks.
    always_comb begin
        src = '0;
        tgt = '0;
        for (int i = 0; i < 3; i++) begin
            if (rod_t'(i) == fr_rod) src = rod_q[i];
            if (rod_t'(i) == to_rod) tgt = rod_q[i];
        end
        mv_bit  = src & (~src + S'(1));
        tgt_low = tgt & (~tgt + S'(1));
        for (int i = 0; i < 3; i++) rod_d[i] = rod_q[i];
        illegal_d = illegal_q;
        if (restart) begin
            rod_d[0]  = '1;
            rod_d[1]  = '0;
            rod_d[2]  = '0;
            illegal_d = 1'b0;
        end else if (hs) begin
            if (src == '0) illegal_d = 1'b1;
            if ((tgt != '0) && (mv_bit > tgt_low)) illegal_d = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (rod_t'(i) == fr_rod) rod_d[i] = rod_d[i] & ~mv_bit;
                if (rod_t'(i) == to_rod) rod_d[i] = rod_d[i] | mv_bit;
            end
        end else if ((state_q == DONE) && (rod_q[2] != '1)) begin
            illegal_d = 1'b1;
        end
    end

    // Shadow rod maps and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rod_q[0]  <= '1;
            rod_q[1]  <= '0;
            rod_q[2]  <= '0;
            illegal_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) rod_q[i] <= rod_d[i];
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_hanoi_solver.sv
// Self-checking bench for hanoi_solver (S=4 and S=3 instances).
// Reference moves come from the classic recursive solution (explicit stack);
// a disk-stack puzzle model replays the DUT's own moves to check legality.
module tb_hanoi_solver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start4 = 1'b0, rdy4 = 1'b0;
    logic       start3 = 1'b0, rdy3 = 1'b0;
    logic       valid4, busy4, done4, ill4;
    logic       valid3, busy3, done3, ill3;
    logic [1:0] fr4, to4, fr3, to3;
    logic [3:0] cnt4;
    logic [2:0] cnt3;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct { int fr; int to; } mv_t;
    typedef struct { int n; int a; int b; int c; } frame_t;
    mv_t ref_q[$];

    int pz_d [3][16];
    int pz_n [3];

    always #5 clk = ~clk;

    hanoi_solver #(.S(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mv_ready(rdy4),
        .mv_valid(valid4), .mv_fr(fr4), .mv_to(to4), .busy(busy4),
        .done(done4), .move_cnt(cnt4), .illegal(ill4)
    );

    hanoi_solver #(.S(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mv_ready(rdy3),
        .mv_valid(valid3), .mv_fr(fr3), .mv_to(to3), .busy(busy3),
        .done(done3), .move_cnt(cnt3), .illegal(ill3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Optimal n-disk solution from rod 0 to rod 2 via recursive decomposition.
    task automatic gen_ref(input int n);
        frame_t st[$];
        frame_t f;
        mv_t m;
        ref_q.delete();
        st.push_back('{n, 0, 2, 1});
        while (st.size() > 0) begin
            f = st.pop_back();
            if (f.n == 1) begin
                m.fr = f.a;
                m.to = f.b;
                ref_q.push_back(m);
            end else begin
                st.push_back('{f.n - 1, f.c, f.b, f.a});
                st.push_back('{1, f.a, f.b, f.c});
                st.push_back('{f.n - 1, f.a, f.c, f.b});
            end
        end
    endtask

    task automatic pz_reset(input int n);
        for (int r = 0; r < 3; r++) pz_n[r] = 0;
        for (int d = n - 1; d >= 0; d--) begin
            pz_d[0][pz_n[0]] = d;
            pz_n[0]++;
        end
    endtask

    task automatic pz_apply(input int fr, input int to, input string tag);
        bit legal;
        legal = (fr < 3) && (to < 3) && (fr != to) && (pz_n[fr] > 0) &&
                ((pz_n[to] == 0) || (pz_d[to][pz_n[to]-1] > pz_d[fr][pz_n[fr]-1]));
        chk(tag, legal, 1);
        if (legal) begin
            pz_d[to][pz_n[to]] = pz_d[fr][pz_n[fr]-1];
            pz_n[to]++;
            pz_n[fr]--;
        end
    endtask

    // rdy_mode: 0 always ready, 1 pattern 1-0-0-1, 2 random.
    // abort_at >= 0 stops after that many handshakes; poke pulses start mid-run.
    task automatic solve4(input int rdy_mode, input int abort_at, input bit poke);
        int idx, cyc, vcyc, ofr, oto;
        bit r;
        gen_ref(4);
        pz_reset(4);
        idx = 0; cyc = 0; vcyc = 0;
        start4 = 1'b1;
        @(negedge clk);
        while (idx < 15 && cyc < 300 && idx != abort_at) begin
            chk("valid4", valid4, 1);
            chk("busy4", busy4, 1);
            chk("done4_run", done4, 0);
            chk("fr4", fr4, ref_q[idx].fr);
            chk("to4", to4, ref_q[idx].to);
            chk("cnt4", cnt4, idx);
            ofr = fr4;
            oto = to4;
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            rdy4   = r;
            start4 = poke && (cyc == 3 || cyc == 4);
            vcyc++;
            @(negedge clk);
            cyc++;
            if (r) begin
                $display("S4 move %0d: rod %0d -> rod %0d", idx + 1, ofr, oto);
                pz_apply(ofr, oto, "pz4_legal");
                idx++;
            end
        end
        start4 = 1'b0;
        rdy4   = 1'b0;
        if (abort_at < 0) begin
            chk("hs4_total", idx, 15);
            chk("done4_end", done4, 1);
            chk("valid4_end", valid4, 0);
            chk("busy4_end", busy4, 0);
            chk("cnt4_end", cnt4, 15);
            chk("illegal4", ill4, 0);
            chk("pz4_rod2", pz_n[2], 4);
            chk("pz4_rod0", pz_n[0], 0);
            if (rdy_mode == 0) chk("cycles4", vcyc, 15);
        end
    endtask

    task automatic solve3();
        int idx, cyc, ofr, oto;
        gen_ref(3);
        pz_reset(3);
        idx = 0; cyc = 0;
        start3 = 1'b1;
        rdy3   = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        while (idx < 7 && cyc < 100) begin
            chk("valid3", valid3, 1);
            chk("fr3", fr3, ref_q[idx].fr);
            chk("to3", to3, ref_q[idx].to);
            ofr = fr3;
            oto = to3;
            @(negedge clk);
            cyc++;
            $display("S3 move %0d: rod %0d -> rod %0d", idx + 1, ofr, oto);
            pz_apply(ofr, oto, "pz3_legal");
            idx++;
        end
        rdy3 = 1'b0;
        chk("done3_end", done3, 1);
        chk("valid3_end", valid3, 0);
        chk("cnt3_end", cnt3, 7);
        chk("illegal3", ill3, 0);
        chk("pz3_rod2", pz_n[2], 3);
    endtask

    task automatic chk_reset4(input string tag);
        chk({tag, "_valid"}, valid4, 0);
        chk({tag, "_busy"}, busy4, 0);
        chk({tag, "_done"}, done4, 0);
        chk({tag, "_cnt"}, cnt4, 0);
        chk({tag, "_fr"}, fr4, 0);
        chk({tag, "_to"}, to4, 0);
        chk({tag, "_ill"}, ill4, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset4("rst4");
        chk("rst3_valid", valid3, 0);
        chk("rst3_done", done3, 0);
        chk("rst3_cnt", cnt3, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_reset4("idle4");

        // Free-running solve, then DONE must hold.
        solve4(0, -1, 0);
        repeat (3) @(negedge clk);
        chk("done4_hold", done4, 1);
        chk("cnt4_hold", cnt4, 15);
        chk("valid4_hold", valid4, 0);

        // Restart from DONE (done drops, move 1 re-issued), then stalled variants.
        solve4(0, -1, 0);
        solve4(1, -1, 0);
        solve4(2, -1, 1);

        solve3();

        // Asynchronous reset while move 6 is on offer, then a clean replay.
        solve4(0, 5, 0);
        rst = 1'b1;
        #1;
        chk_reset4("midrst4");
        @(negedge clk);
        chk_reset4("midrst4_next");
        rst = 1'b0;
        @(negedge clk);
        solve4(0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
